// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for Pong: serve/play/miss/over sequencing, lives, BCD score and speed level.
// Buttons are synchronised and edge-detected; every output is driven straight from a flop.
module pong_game_ctrl #(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned MISS_FRAMES    = 63,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned MAX_SPEED      = 3
) (
    input  logic       clk25,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       hit_pulse,
    input  logic       miss_pulse,
    output logic       ball_run,
    output logic       ball_center,
    output logic [1:0] speed,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       flash,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPause = 3'd3,
        StMiss  = 3'd4,
        StOver  = 3'd5
    } state_e;

    localparam int unsigned TimerW = 8;

    state_e            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [7:0]        score_q, score_d;
    logic [1:0]        speed_q, speed_d;
    logic [3:0]        hit_cnt_q, hit_cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [4:0]        frame_cnt_q, frame_cnt_d;
    logic              ball_run_q, ball_run_d;
    logic              ball_center_q, ball_center_d;
    logic              flash_q, flash_d;

    logic [1:0] start_sync_q, pause_sync_q;
    logic       start_prev_q, pause_prev_q;
    logic       start_p_q, pause_p_q;
    logic [1:0] settle_q;
    logic       armed;
    logic       do_start;

    // Edge detection stays masked until the synchronisers hold real samples, so a button
    // held through reset release never produces a pulse.
    assign armed = (settle_q == 2'd3);

    always_ff @(posedge clk25 or negedge Reset_n) begin
        if (!Reset_n) begin
            start_sync_q <= 2'b00;
            pause_sync_q <= 2'b00;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            start_p_q    <= 1'b0;
            pause_p_q    <= 1'b0;
            settle_q     <= 2'd0;
        end else begin
            start_sync_q <= {start_sync_q[0], start_btn};
            pause_sync_q <= {pause_sync_q[0], pause_btn};
            start_prev_q <= start_sync_q[1];
            pause_prev_q <= pause_sync_q[1];
            start_p_q    <= armed & start_sync_q[1] & ~start_prev_q;
            pause_p_q    <= armed & pause_sync_q[1] & ~pause_prev_q;
            if (!armed) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        speed_d     = speed_q;
        hit_cnt_d   = hit_cnt_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;
        do_start    = 1'b0;

        case (state_q)
            StIdle: begin
                do_start = start_p_q;
            end
            StServe: begin
                if (frame_tick) begin
                    if (timer_q == '0) begin
                        state_d = StPlay;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            StPlay: begin
                if (miss_pulse) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d     = StOver;
                        frame_cnt_d = '0;
                    end else begin
                        state_d = StMiss;
                        timer_d = TimerW'(MISS_FRAMES - 1);
                    end
                end else begin
                    if (hit_pulse) begin
                        if (score_q[3:0] == 4'd9) begin
                            score_d[3:0] = 4'd0;
                            score_d[7:4] = (score_q[7:4] == 4'd9) ? 4'd0 : score_q[7:4] + 4'd1;
                        end else begin
                            score_d[3:0] = score_q[3:0] + 4'd1;
                        end
                        if (hit_cnt_q == 4'(HITS_PER_LEVEL - 1)) begin
                            hit_cnt_d = '0;
                            if (speed_q < 2'(MAX_SPEED)) begin
                                speed_d = speed_q + 2'd1;
                            end
                        end else begin
                            hit_cnt_d = hit_cnt_q + 4'd1;
                        end
                    end
                    if (pause_p_q) begin
                        state_d = StPause;
                    end
                end
            end
            StPause: begin
                if (pause_p_q) begin
                    state_d = StPlay;
                end
            end
            StMiss: begin
                if (frame_tick) begin
                    if (timer_q == '0) begin
                        state_d   = StServe;
                        timer_d   = TimerW'(SERVE_FRAMES - 1);
                        speed_d   = 2'd1;
                        hit_cnt_d = '0;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            StOver: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + 5'd1;
                end
                do_start = start_p_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_start) begin
            state_d   = StServe;
            lives_d   = 2'(LIVES);
            score_d   = 8'h00;
            speed_d   = 2'd1;
            hit_cnt_d = '0;
            timer_d   = TimerW'(SERVE_FRAMES - 1);
        end

        // Outputs are decoded from the next state so they land in flops alongside it.
        ball_run_d    = (state_d == StPlay);
        ball_center_d = (state_d == StIdle) || (state_d == StServe) || (state_d == StOver);
        flash_d       = (state_d == StMiss) || ((state_d == StOver) && frame_cnt_d[4]);
    end

    always_ff @(posedge clk25 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            lives_q       <= 2'(LIVES);
            score_q       <= 8'h00;
            speed_q       <= 2'd1;
            hit_cnt_q     <= '0;
            timer_q       <= '0;
            frame_cnt_q   <= '0;
            ball_run_q    <= 1'b0;
            ball_center_q <= 1'b1;
            flash_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            speed_q       <= speed_d;
            hit_cnt_q     <= hit_cnt_d;
            timer_q       <= timer_d;
            frame_cnt_q   <= frame_cnt_d;
            ball_run_q    <= ball_run_d;
            ball_center_q <= ball_center_d;
            flash_q       <= flash_d;
        end
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign speed       = speed_q;
    assign ball_run    = ball_run_q;
    assign ball_center = ball_center_q;
    assign flash       = flash_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: full game flow with hand-computed expectations.
module tb_pong_game_ctrl;

    logic       clk25;
    logic       Reset_n;
    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       ball_run;
    logic       ball_center;
    logic [1:0] speed;
    logic [1:0] lives;
    logic [7:0] score;
    logic       flash;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    localparam int SIdle = 0, SServe = 1, SPlay = 2, SPause = 3, SMiss = 4, SOver = 5;

    pong_game_ctrl dut (
        .clk25      (clk25),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .ball_run   (ball_run),
        .ball_center(ball_center),
        .speed      (speed),
        .lives      (lives),
        .score      (score),
        .flash      (flash),
        .state      (state)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit_pulse = 1'b1;
            tick(1);
            hit_pulse = 1'b0;
        end
    endtask

    task automatic miss_once(input bit with_hit);
        miss_pulse = 1'b1;
        hit_pulse  = with_hit;
        tick(1);
        miss_pulse = 1'b0;
        hit_pulse  = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick(4);
        start_btn = 1'b0;
        tick(3);
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        tick(4);
        pause_btn = 1'b0;
        tick(3);
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        pause_btn  = 1'b0;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        tick(2);
        check_eq("rst_state", state, SIdle);
        check_eq("rst_lives", lives, 3);
        check_eq("rst_score", score, 8'h00);
        check_eq("rst_speed", speed, 1);
        check_eq("rst_run", ball_run, 0);
        check_eq("rst_center", ball_center, 1);
        check_eq("rst_flash", flash, 0);
        Reset_n = 1'b1;
        tick(4);

        // Start press: SERVE on the fourth edge after the button rises.
        start_btn = 1'b1;
        tick(3);
        check_eq("start_lat3", state, SIdle);
        tick(1);
        check_eq("start_lat4", state, SServe);
        tick(1);
        start_btn = 1'b0;
        tick(3);
        frames(59);
        check_eq("serve_59", state, SServe);
        frames(1);
        check_eq("serve_60", state, SPlay);
        check_eq("play_run", ball_run, 1);
        check_eq("play_center", ball_center, 0);

        // Hits, BCD score and speed steps.
        hits(4);
        check_eq("speed_h4", speed, 1);
        hits(1);
        check_eq("speed_h5", speed, 2);
        check_eq("score_h5", score, 8'h05);
        hits(7);
        check_eq("score_h12", score, 8'h12);
        check_eq("speed_h12", speed, 3);
        hits(3);
        check_eq("score_h15", score, 8'h15);
        check_eq("speed_sat", speed, 3);
        hits(84);
        check_eq("score_99", score, 8'h99);
        hits(1);
        check_eq("score_wrap", score, 8'h00);
        check_eq("wrap_state", state, SPlay);

        // Hit coinciding with miss: miss wins.
        miss_once(1'b1);
        check_eq("hm_score", score, 8'h00);
        check_eq("hm_lives", lives, 2);
        check_eq("miss_state", state, SMiss);
        check_eq("miss_flash", flash, 1);
        check_eq("miss_run", ball_run, 0);
        check_eq("miss_center", ball_center, 0);
        frames(62);
        check_eq("miss_62", state, SMiss);
        frames(1);
        check_eq("miss_63", state, SServe);
        check_eq("miss_speed", speed, 1);
        check_eq("miss_flash_off", flash, 0);
        frames(60);
        check_eq("serve2_play", state, SPlay);

        // Pause freezes the game and ignores events.
        press_pause();
        check_eq("pause_state", state, SPause);
        check_eq("pause_run", ball_run, 0);
        check_eq("pause_center", ball_center, 0);
        hits(1);
        miss_once(1'b0);
        frames(5);
        check_eq("pause_score", score, 8'h00);
        check_eq("pause_lives", lives, 2);
        check_eq("pause_hold", state, SPause);
        press_pause();
        check_eq("unpause", state, SPlay);
        hits(1);
        check_eq("post_pause_hit", score, 8'h01);

        // Remaining lives to game over.
        miss_once(1'b0);
        check_eq("lives_1", lives, 1);
        frames(63);
        frames(60);
        check_eq("play3", state, SPlay);
        miss_once(1'b0);
        check_eq("over_state", state, SOver);
        check_eq("over_lives", lives, 0);
        check_eq("over_center", ball_center, 1);
        check_eq("over_flash0", flash, 0);
        frames(15);
        check_eq("over_flash15", flash, 0);
        frames(1);
        check_eq("over_flash16", flash, 1);
        frames(15);
        check_eq("over_flash31", flash, 1);
        frames(1);
        check_eq("over_flash32", flash, 0);
        hits(1);
        check_eq("over_score", score, 8'h01);
        press_start();
        check_eq("restart_state", state, SServe);
        check_eq("restart_lives", lives, 3);
        check_eq("restart_score", score, 8'h00);
        check_eq("restart_speed", speed, 1);

        // Asynchronous reset mid-MISS with start held through release.
        frames(60);
        miss_once(1'b0);
        frames(10);
        check_eq("pre_rst_miss", state, SMiss);
        start_btn = 1'b1;
        #5;
        Reset_n = 1'b0;
        #1;
        check_eq("arst_state", state, SIdle);
        check_eq("arst_flash", flash, 0);
        check_eq("arst_lives", lives, 3);
        check_eq("arst_center", ball_center, 1);
        check_eq("arst_run", ball_run, 0);
        tick(1);
        Reset_n = 1'b1;
        tick(10);
        check_eq("held_no_start", state, SIdle);
        start_btn = 1'b0;
        tick(3);
        start_btn = 1'b1;
        tick(3);
        check_eq("repress_lat3", state, SIdle);
        tick(1);
        check_eq("repress_lat4", state, SServe);
        start_btn = 1'b0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
